// File: rtl/wb_trace_fifo.sv
// Serialises up to LANES commit records per cycle into the one-record-per-cycle
// debug writeback trace, using a circular FIFO with group-level back-pressure.
module wb_trace_fifo #(
  parameter int LANES       = 2,
  parameter int DEPTH       = 8,
  parameter bit FILTER_NOWB = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*32-1:0]          in_pc,
  input  logic [LANES*4-1:0]           in_wen,
  input  logic [LANES*5-1:0]           in_wnum,
  input  logic [LANES*32-1:0]          in_wdata,
  output logic                         in_ready,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [31:0] pc_mem    [DEPTH];
  logic [3:0]  wen_mem   [DEPTH];
  logic [4:0]  wnum_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             err_reg;

  logic [LANES-1:0] eligible;
  logic [PW-1:0]    slot [LANES];
  logic [LW-1:0]    push_cnt;
  logic [LW-1:0]    push_amt;
  logic [LW-1:0]    pop_amt;
  logic             any_valid;
  logic             accept;
  logic             pop;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_elig
      assign eligible[gi] = in_valid[gi] &&
                            (!FILTER_NOWB || (in_wen[gi*4 +: 4] != 4'h0));
    end
  endgenerate

  // Each eligible lane lands at write pointer + number of older eligible lanes.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wr_ptr_reg + push_cnt[PW-1:0];
      if (eligible[i]) begin
        push_cnt = push_cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (level_reg <= LW'(DEPTH - LANES));
  assign any_valid = |in_valid;
  assign accept    = in_ready && any_valid;
  assign pop       = (level_reg != '0);
  assign push_amt  = accept ? push_cnt : '0;
  assign pop_amt   = pop ? LW'(1) : '0;

  // Storage needs no reset: pointers and level define which slots are live.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (eligible[i]) begin
          pc_mem[slot[i]]    <= in_pc[i*32 +: 32];
          wen_mem[slot[i]]   <= in_wen[i*4 +: 4];
          wnum_mem[slot[i]]  <= in_wnum[i*5 +: 5];
          wdata_mem[slot[i]] <= in_wdata[i*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      level_reg         <= '0;
      err_reg           <= 1'b0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + push_cnt[PW-1:0];
      end
      if (any_valid && !in_ready) begin
        err_reg <= 1'b1;
      end
      level_reg <= level_reg + push_amt - pop_amt;
      if (pop) begin
        rd_ptr_reg        <= rd_ptr_reg + 1'b1;
        debug_wb_pc       <= pc_mem[rd_ptr_reg];
        debug_wb_rf_wen   <= wen_mem[rd_ptr_reg];
        debug_wb_rf_wnum  <= wnum_mem[rd_ptr_reg];
        debug_wb_rf_wdata <= wdata_mem[rd_ptr_reg];
      end else begin
        debug_wb_rf_wen   <= '0;
      end
    end
  end

  assign level        = level_reg;
  assign overflow_err = err_reg;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Instance 1 has the filter off.
module tb_wb_trace_fifo;
  localparam int LANES = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  nf_valid = '0;
  logic [63:0] in_pc = '0;
  logic [7:0]  in_wen = '0;
  logic [9:0]  in_wnum = '0;
  logic [63:0] in_wdata = '0;

  logic        o_ready [2];
  logic [31:0] o_pc    [2];
  logic [3:0]  o_wen   [2];
  logic [4:0]  o_wnum  [2];
  logic [31:0] o_wdata [2];
  logic [3:0]  o_level [2];
  logic        o_err   [2];

  int checks = 0;
  int failures = 0;

  rec_t mq [2][$];
  rec_t mout [2];
  bit   merr [2];

  int          cyc = 0;
  bit          logging = 0;
  logic [31:0] log_pc [$];
  int          log_cyc [$];
  bit          forbid_en = 0;
  bit          forbid_seen = 0;
  logic [31:0] forbid_lo = '0;
  logic [31:0] forbid_hi = '0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .FILTER_NOWB(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_wen(in_wen),
    .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(o_ready[0]),
    .debug_wb_pc(o_pc[0]), .debug_wb_rf_wen(o_wen[0]), .debug_wb_rf_wnum(o_wnum[0]),
    .debug_wb_rf_wdata(o_wdata[0]), .level(o_level[0]), .overflow_err(o_err[0])
  );

  wb_trace_fifo #(.LANES(LANES), .DEPTH(DEPTH), .FILTER_NOWB(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .in_valid(nf_valid), .in_pc(in_pc), .in_wen(in_wen),
    .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(o_ready[1]),
    .debug_wb_pc(o_pc[1]), .debug_wb_rf_wen(o_wen[1]), .debug_wb_rf_wnum(o_wnum[1]),
    .debug_wb_rf_wdata(o_wdata[1]), .level(o_level[1]), .overflow_err(o_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue per instance; pop precedes push at each edge.
  initial begin
    logic [1:0] v;
    bit         rdy;
    rec_t       r;
    forever begin
      @(posedge clk or posedge reset);
      for (int m = 0; m < 2; m++) begin
        if (reset) begin
          mq[m].delete();
          mout[m] = '0;
          merr[m] = 1'b0;
        end else begin
          v   = (m == 0) ? in_valid : nf_valid;
          rdy = (DEPTH - mq[m].size()) >= LANES;
          if (mq[m].size() > 0) mout[m] = mq[m].pop_front();
          else mout[m].wen = 4'h0;
          if (v != 2'b00) begin
            if (!rdy) merr[m] = 1'b1;
            else begin
              for (int i = 0; i < LANES; i++) begin
                if (v[i] && (m == 1 || in_wen[i*4 +: 4] != 4'h0)) begin
                  r.pc    = in_pc[i*32 +: 32];
                  r.wen   = in_wen[i*4 +: 4];
                  r.wnum  = in_wnum[i*5 +: 5];
                  r.wdata = in_wdata[i*32 +: 32];
                  mq[m].push_back(r);
                end
              end
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus trace logging for instance 0.
  initial begin
    string pfx;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        pfx = (m == 0) ? "f_" : "nf_";
        chk({pfx, "level"},    32'(o_level[m]), 32'(mq[m].size()));
        chk({pfx, "in_ready"}, 32'(o_ready[m]), 32'((DEPTH - mq[m].size()) >= LANES));
        chk({pfx, "wen"},      32'(o_wen[m]),   32'(mout[m].wen));
        chk({pfx, "pc"},       o_pc[m],         mout[m].pc);
        chk({pfx, "wnum"},     32'(o_wnum[m]),  32'(mout[m].wnum));
        chk({pfx, "wdata"},    o_wdata[m],      mout[m].wdata);
        chk({pfx, "ovf_err"},  32'(o_err[m]),   32'(merr[m]));
      end
      if (o_wen[0] != 4'h0) begin
        if (logging) begin
          log_pc.push_back(o_pc[0]);
          log_cyc.push_back(cyc);
        end
        if (forbid_en && o_pc[0] >= forbid_lo && o_pc[0] <= forbid_hi) forbid_seen = 1'b1;
      end
      cyc++;
    end
  end

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wd);
    in_pc[i*32 +: 32]    = pc;
    in_wen[i*4 +: 4]     = wen;
    in_wnum[i*5 +: 5]    = wnum;
    in_wdata[i*32 +: 32] = wd;
  endtask

  task automatic grp(input logic [31:0] base);
    set_lane(0, base,         4'hF, base[6:2], ~base);
    set_lane(1, base + 32'd4, 4'h3, base[7:3], base ^ 32'h5A5A_0000);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (o_level[0] != 4'd0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_level", 32'(o_level[0]), 32'd0);
    chk("rst_wen",   32'(o_wen[0]),   32'd0);
    chk("rst_pc",    o_pc[0],         32'd0);
    chk("rst_ready", 32'(o_ready[0]), 32'd1);
    chk("rst_err",   32'(o_err[0]),   32'd0);

    // Single lane
    set_lane(0, 32'hBFC0_0000, 4'hF, 5'd3, 32'h11);
    in_valid = 2'b01;
    @(negedge clk);
    in_valid = 2'b00;
    chk("t1_level_e1", 32'(o_level[0]), 32'd1);
    chk("t1_wen_e1",   32'(o_wen[0]),   32'd0);
    @(negedge clk);
    chk("t1_pc",    o_pc[0],         32'hBFC0_0000);
    chk("t1_wen",   32'(o_wen[0]),   32'hF);
    chk("t1_wnum",  32'(o_wnum[0]),  32'd3);
    chk("t1_wdata", o_wdata[0],      32'h11);
    chk("t1_level", 32'(o_level[0]), 32'd0);
    @(negedge clk);
    chk("t1_idle_wen", 32'(o_wen[0]), 32'd0);

    // Dual-lane ordering
    set_lane(0, 32'h100, 4'hF, 5'd1, 32'hAAAA_0001);
    set_lane(1, 32'h104, 4'hF, 5'd2, 32'hAAAA_0002);
    in_valid = 2'b11;
    @(negedge clk);
    in_valid = 2'b00;
    chk("t2_level0", 32'(o_level[0]), 32'd2);
    @(negedge clk);
    chk("t2_pc0",    o_pc[0],         32'h100);
    chk("t2_level1", 32'(o_level[0]), 32'd1);
    @(negedge clk);
    chk("t2_pc1",    o_pc[0],         32'h104);
    chk("t2_level2", 32'(o_level[0]), 32'd0);
    @(negedge clk);

    // Filter on (dut) vs off (dut_nf)
    set_lane(0, 32'h200, 4'h0, 5'd4, 32'hBBBB_0000);
    set_lane(1, 32'h208, 4'hF, 5'd5, 32'hBBBB_0008);
    in_valid = 2'b11;
    nf_valid = 2'b11;
    @(negedge clk);
    in_valid = 2'b00;
    nf_valid = 2'b00;
    chk("t3_f_level",  32'(o_level[0]), 32'd1);
    chk("t3_nf_level", 32'(o_level[1]), 32'd2);
    @(negedge clk);
    chk("t3_f_pc",   o_pc[0],        32'h208);
    chk("t3_f_wen",  32'(o_wen[0]),  32'hF);
    chk("t3_nf_pc0", o_pc[1],        32'h200);
    @(negedge clk);
    chk("t3_f_idle", 32'(o_wen[0]),  32'd0);
    chk("t3_nf_pc1", o_pc[1],        32'h208);
    @(negedge clk);
    chk("t3_nf_idle", 32'(o_wen[1]), 32'd0);

    // Full groups every cycle; core only presents a group while in_ready is 1
    logging = 1'b1;
    g = 0;
    for (int n = 0; n < 200 && g < 10; n++) begin
      if (o_ready[0]) begin
        grp(32'h1000 + 32'(g * 8));
        in_valid = 2'b11;
        g++;
      end else begin
        in_valid = 2'b00;
        chk("t4_bp_level", 32'(o_level[0]), 32'd7);
      end
      @(negedge clk);
    end
    in_valid = 2'b00;
    chk("t4_groups", 32'(g), 32'd10);
    drain(40);
    logging = 1'b0;
    chk("t4_count", 32'(log_pc.size()), 32'd20);
    for (int n = 0; n < log_pc.size() && n < 20; n++) begin
      chk("t4_order", log_pc[n], 32'h1000 + 32'(4 * n));
      chk("t4_gap", 32'(log_cyc[n] - log_cyc[0]), 32'(n));
    end

    // Violation: fill until not ready, then push anyway
    g = 0;
    while (o_ready[0] && g < 20) begin
      grp(32'h3000 + 32'(g * 8));
      in_valid = 2'b11;
      @(negedge clk);
      g++;
    end
    chk("t5_fill_groups", 32'(g), 32'd6);
    forbid_lo = 32'hDEAD_0000;
    forbid_hi = 32'hDEAD_0004;
    forbid_en = 1'b1;
    set_lane(0, 32'hDEAD_0000, 4'hF, 5'd7, 32'h0);
    set_lane(1, 32'hDEAD_0004, 4'hF, 5'd8, 32'h0);
    in_valid = 2'b11;
    @(negedge clk);
    in_valid = 2'b00;
    chk("t5_err",   32'(o_err[0]),   32'd1);
    chk("t5_level", 32'(o_level[0]), 32'd6);
    drain(40);
    chk("t5_err_sticky", 32'(o_err[0]),   32'd1);
    chk("t5_dropped",    32'(forbid_seen), 32'd0);
    forbid_en = 1'b0;

    // Reset mid-drain at level 5
    for (int n = 0; n < 4; n++) begin
      grp(32'h5000 + 32'(n * 8));
      in_valid = 2'b11;
      @(negedge clk);
    end
    in_valid = 2'b00;
    chk("t6_level_pre", 32'(o_level[0]), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_wen",   32'(o_wen[0]),   32'd0);
    chk("t6_rst_level", 32'(o_level[0]), 32'd0);
    chk("t6_rst_ready", 32'(o_ready[0]), 32'd1);
    chk("t6_rst_err",   32'(o_err[0]),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    forbid_lo   = 32'h5000;
    forbid_hi   = 32'h50FF;
    forbid_seen = 1'b0;
    forbid_en   = 1'b1;
    grp(32'h6000);
    in_valid = 2'b11;
    @(negedge clk);
    in_valid = 2'b00;
    chk("t6_level_new", 32'(o_level[0]), 32'd2);
    @(negedge clk);
    chk("t6_first_pc", o_pc[0], 32'h6000);
    drain(20);
    chk("t6_stale", 32'(forbid_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Multi-lane writeback trace serialiser placed between the core's commit stage and the `debug_wb_*` top-level ports. It lets a core that retires up to LANES instructions per cycle drive the single-entry-per-cycle debug trace. Each cycle it accepts a group of commit records, stores them in order in a circular FIFO, and emits at most one record per cycle. When the FIFO cannot take a full group, it back-pressures the core.

## Interface
Parameters:
- LANES, 2: commit lanes per cycle. Lane 0 is the oldest instruction in the group. Legal range is 1..4.
- DEPTH, 8: FIFO entries. Must be a power of two and ≥ LANES.
- FILTER_NOWB, 1: when 1, a lane with `in_wen == 0` is discarded and not enqueued. When 0, every valid lane is enqueued.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  LANES  per-lane commit-record valid.
- in_pc  in  LANES×32  per-lane PC.
- in_wen  in  LANES×4  per-lane register-write strobe.
- in_wnum  in  LANES×5  per-lane destination register index.
- in_wdata  in  LANES×32  per-lane write data.
- in_ready  out  1  FIFO can take a full group this cycle. Combinational from the current occupancy.
- debug_wb_pc  out  32  PC of the emitted record. Registered.
- debug_wb_rf_wen  out  4  write strobe of the emitted record; 0 when nothing is emitted. Registered.
- debug_wb_rf_wnum  out  5  destination register of the emitted record. Registered.
- debug_wb_rf_wdata  out  32  write data of the emitted record. Registered.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow_err  out  1  sticky protocol-violation flag.

## Operation
- **Ready:** `in_ready = (DEPTH − level) ≥ LANES`. This is a worst-case check: the FIFO must have room for all LANES entries, independent of how many lanes are valid.
- **Group accept:** a group is accepted at an edge when `in_ready` is 1 and any `in_valid` bit is 1.
- **Eligible lanes:** a lane is eligible when `in_valid[i]` is 1 and either FILTER_NOWB is 0 or `in_wen[i] != 0`.
- **Compaction:** eligible lanes are written to consecutive slots starting at the write pointer, in ascending lane order. Ineligible lanes leave no holes. The write pointer advances by the number of eligible lanes, modulo DEPTH.
- **Pop:** at every edge where `level > 0` (evaluated before this edge's push), the head entry is loaded into the debug output registers and the read pointer advances by 1, modulo DEPTH.
- **Idle output:** at an edge with no pop, `debug_wb_rf_wen` is loaded with 0. pc, wnum and wdata hold their previous values.
- **Occupancy update:** `level_next = level + pushes − pop`. Pushes and a pop at the same edge are both performed.
- **Pointer wrap:** read and write pointers are $clog2(DEPTH) bits. A push whose slots span the end of storage wraps past slot DEPTH−1 to slot 0.
- **Protocol violation:** `in_ready` is 0 while any `in_valid` bit is 1 at an edge. Then:
  - the group is dropped entirely;
  - `overflow_err` is set and stays 1 until reset;
  - FIFO contents, pointers and `level` are unaffected.
- **Ordering:** records leave in strict acceptance order: across groups by acceptance edge, within a group by lane index. No record is duplicated or lost, except groups dropped by a violation.

## Timing
- **Reset values (asynchronous):**
  - read and write pointers 0, `level` 0, `overflow_err` 0;
  - `debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata` all 0;
  - `in_ready` 1 immediately, because DEPTH ≥ LANES.
- **Latency:** a record accepted at edge k into an empty FIFO is written to storage at k. It is popped at edge k+1 and is visible on the debug outputs from k+1 until k+2. There is no bypass path.
- **Throughput:** one record out per cycle. A group of n eligible lanes therefore drains over n consecutive cycles.
- **Back-pressure:** `in_ready` drops in the same cycle that occupancy exceeds DEPTH − LANES. It rises in the cycle after the pop that frees enough space.
- **Reset mid-operation:**
  - all queued records are discarded;
  - outputs go to their reset values asynchronously;
  - the first edge after reset deassertion behaves as from an empty FIFO.
- **Draining after input stops:** with no further input, a FIFO holding L entries produces exactly L consecutive non-zero-`wen` cycles (assuming FILTER_NOWB = 1), then `wen = 0`.

## Test plan
1. **Single lane.** LANES=2, FILTER_NOWB=1. At edge 1, lane 0 = (pc 0xBFC00000, wen 0xF, wnum 3, wdata 0x11) and lane 1 invalid.
   - Required: after edge 2, outputs show that record with `level` = 0.
   - Required: after edge 3, `wen` = 0.
2. **Dual-lane ordering.** Lane 0 pc 0x100, lane 1 pc 0x104, both with wen 0xF.
   - Required: pc 0x100 after edge k+1, then pc 0x104 after edge k+2.
   - Required: `level` sequence is 2, 1, 0.
3. **Filter.** FILTER_NOWB=1. Lane 0 wen 0, lane 1 wen 0xF at pc 0x208.
   - Required: only pc 0x208 is emitted, and `level` peaks at 1.
   - Repeat with FILTER_NOWB=0: both records are emitted.
4. **Full and back-pressure.** DEPTH=8, LANES=2. Drive full groups every cycle.
   - Required: `in_ready` goes to 0 once `level` > 6.
   - Required: the core holds its group until `in_ready` returns; 20 records leave in order with no gaps and no duplicates.
   - Required: pointers wrap correctly past slot 7.
5. **Violation.** Force `in_valid = 2'b11` while `in_ready` = 0.
   - Required: `overflow_err` = 1 and stays 1; `level` is unchanged; the dropped PCs never appear on the outputs.
6. **Reset mid-drain.** With `level` = 5, assert `reset` between edges.
   - Required: `debug_wb_rf_wen` = 0, `level` = 0 and `in_ready` = 1 immediately.
   - Required: after release, none of the pre-reset records are emitted.
